mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one single-port memory bus between instruction fetch (driven by the PC register's pc/ce) and the MEM-stage load/store unit.
- Serialises requests, holds each request stable until the slave acks, and buffers returned data until the pipeline consumes it.
- Raises per-requester stall requests to the pipeline controller.
- Sits between the pipeline (pc register, if_id, mem stage, ctrl) and the external bus.

Parameters:
- ADDR_W, 32, address width (matches `InstAddrBus`/`DataAddrBus`).
- DATA_W, 32, data width.
- SEL_W, 4, byte-select width (DATA_W/8).

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  reset; synchronous, active-high (asserted value is `RstEnable`).
- stall  in  6  pipeline stall vector from ctrl: [0]pc [1]if [2]id [3]ex [4]mem [5]wb; `StallDisable`=0.
- flush  in  1  pipeline flush from ctrl (exception/eret).
- if_ce  in  1  fetch enable (pc register ce).
- if_addr  in  ADDR_W  fetch address (pc).
- if_inst  out  DATA_W  fetched instruction.
- stallreq_if  out  1  fetch not yet complete.
- mem_ce  in  1  data access enable.
- mem_we  in  1  1=store, 0=load.
- mem_sel  in  SEL_W  byte enables.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data.
- stallreq_mem  out  1  data access not yet complete.
- bus_req  out  1  bus request, held until ack.
- bus_we  out  1  bus write enable.
- bus_sel  out  SEL_W  bus byte enables.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_rdata  in  DATA_W  bus read data, valid with ack.
- bus_ack  in  1  slave completion, one cycle per transfer.

Behaviour:
- FSM states:
  - S_IDLE: no transfer in flight.
  - S_MEM: data transfer in flight.
  - S_IF: fetch transfer in flight.
- Pending requests:
  - mem_pend = mem_ce & ~mem_done.
  - if_pend = if_ce & ~if_done & ~flush.
- Arbitration (S_IDLE only):
  - mem_pend wins; otherwise if_pend. The older instruction has priority.
  - On grant, next edge: bus_req=1, bus_we/sel/addr/wdata registered from the winner. Fetches use bus_we=0 and bus_sel=4'hF.
- Request hold: while in S_MEM/S_IF, all bus_* outputs are held constant until bus_ack. Inputs changing mid-transfer are ignored.
- On bus_ack, at the next edge:
  - bus_req=0 and state goes to S_IDLE.
  - For S_MEM: mem_buf<=bus_rdata (store captures rdata too, unused) and mem_done<=1.
  - For S_IF: if_buf<=bus_rdata and if_done<=1, unless the discard flag is set.
  - There is always one idle cycle between transfers; no back-to-back grant.
- Minimum latency: request first seen cycle N -> bus_req at N+1 -> ack at N+1 (zero-wait slave) -> done at N+2. The stall request is therefore high in cycles N and N+1.
- Outputs:
  - stallreq_mem = mem_ce & ~mem_done.
  - stallreq_if = if_ce & ~if_done.
  - Both are combinational from registered state.
  - mem_rdata = mem_done ? mem_buf : 0.
  - if_inst = if_done ? if_buf : 0 (NOP).
- Consumption:
  - mem_done clears at an edge where stall[4]==`StallDisable`.
  - if_done clears at an edge where stall[1]==`StallDisable`.
  - If a stage is stalled by another requester, its done flag and buffer are held.
- Flush:
  - At the flush edge, if_done<=0 and mem_done<=0.
  - If state is S_IF, set discard; the ack still completes the bus cycle, data is dropped, and discard clears.
  - An in-flight S_MEM transfer completes normally. Its result is dropped because mem_done is cleared on the following consumption.
- Simultaneous events:
  - ack and flush in the same cycle: flush wins, and the fetch result is discarded.
  - ack and a done-clear in the same cycle cannot conflict, because done is only set from an in-flight transfer.
- Reset (edge with rst=1):
  - state=S_IDLE, and bus_req, bus_we, bus_sel, bus_addr, bus_wdata = 0.
  - if_buf, mem_buf, if_done, mem_done and discard = 0.
  - Reset mid-transfer abandons the transfer immediately; the slave must tolerate bus_req dropping.
- if_ce=0 (pc register disabled) never generates a request.

Decomposition:
- Shared defines header: state encodings (S_IDLE, S_MEM, S_IF), stall bit indices (STALL_IF=1, STALL_MEM=4), and the existing `RstEnable`/`StallDisable`/`ZeroWord` macros.
- Optional sub-module mem_bus_result_buf (data register + done flag + clear-on-advance), instantiated twice, once per requester.

Test Plan:
- Fetch only, zero-wait slave returning 32'h24020005 at addr 0: stallreq_if is high for 2 cycles, then if_inst=32'h24020005. if_done clears at the next edge with stall=0.
- Simultaneous if_ce and mem load at 0x100 (rdata 32'hDEADBEEF): the MEM transfer is granted first and mem_rdata=32'hDEADBEEF. After one idle cycle the fetch is granted, and stallreq_if stays high throughout.
- Slave with 3 wait states, store sel=4'b0011, addr 0x200, wdata 32'h0000ABCD: bus_addr, sel and wdata are stable for all 4 req cycles, and stallreq_mem drops 1 cycle after ack.
- Flush asserted during an S_IF fetch: the ack data is discarded, if_inst stays 0, and a new fetch is issued for the updated if_addr.
- Fetch done while stall=6'b000111 held for 3 cycles: if_inst stays constant, no new bus request is issued, and if_done clears on the first edge with stall[1]=0.
- rst asserted mid S_MEM: at the next edge bus_req=0, all outputs are 0 and state is S_IDLE. After rst deasserts, the next request is granted normally.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the memory bus arbiter.
//   - FSM state encodings (S_IDLE, S_MEM, S_IF)
//   - stall vector bit indices used to detect pipeline advance
//   - reset / stall-disable / zero-word values inherited from the core
package mem_bus_arbiter_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_IF   = 2'd2;

  localparam int STALL_IF  = 1;
  localparam int STALL_MEM = 4;

  localparam logic        RST_ENABLE    = 1'b1;
  localparam logic        STALL_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

endpackage

// File: rtl/mem_bus_arbiter_buf.sv
// Result buffer for one requester: captures returned bus data with a done
// flag and drops the flag once the owning pipeline stage advances.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   set_i     - capture data_i and raise done (wins over clr_i)
//   clr_i     - clear done (flush or stage advance)
//   data_i    - data from the bus
//   done_o    - result is valid
//   data_o    - buffered data, forced to zero while not done
module mem_bus_arbiter_buf
  import mem_bus_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              done_o,
  output logic [DATA_W-1:0] data_o
);

  logic              done_q, done_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  // A set can only come from a transfer granted while done was low, so it
  // never collides with a consumption clear; it only meets a flush clear.
  always_comb begin
    done_d = done_q;
    buf_d  = buf_q;
    if (set_i) begin
      done_d = 1'b1;
      buf_d  = data_i;
    end else if (clr_i) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      done_q <= 1'b0;
      buf_q  <= '0;
    end else begin
      done_q <= done_d;
      buf_q  <= buf_d;
    end
  end

  assign done_o = done_q;
  assign data_o = done_q ? buf_q : '0;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates a single-port memory bus between instruction fetch and the
// MEM-stage load/store unit. One transfer at a time, request held until
// ack, result buffered until the requesting stage advances.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   stall[5:0], flush         - pipeline control from ctrl
//   if_ce, if_addr            - fetch request;  if_inst, stallreq_if out
//   mem_ce/we/sel/addr/wdata  - data request;   mem_rdata, stallreq_mem out
//   bus_req/we/sel/addr/wdata - registered bus request outputs
//   bus_rdata, bus_ack        - slave response
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic              if_ce,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_inst,
  output logic              stallreq_if,
  input  logic              mem_ce,
  input  logic              mem_we,
  input  logic [SEL_W-1:0]  mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stallreq_mem,
  output logic              bus_req,
  output logic              bus_we,
  output logic [SEL_W-1:0]  bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  logic [1:0]        state_q, state_d;
  logic              discard_q, discard_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic mem_done, if_done;
  logic mem_pend, if_pend;
  logic mem_set, if_set;
  logic mem_clr, if_clr;

  // Only the IF and MEM stall bits gate consumption.
  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[3:2], stall[0]};

  assign mem_pend = mem_ce & ~mem_done;
  assign if_pend  = if_ce & ~if_done & ~flush;

  assign mem_clr = flush | (mem_done & (stall[STALL_MEM] == STALL_DISABLE));
  assign if_clr  = flush | (if_done & (stall[STALL_IF] == STALL_DISABLE));

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    req_d     = req_q;
    we_d      = we_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mem_set   = 1'b0;
    if_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Data access belongs to the older instruction, so it wins.
        if (mem_pend) begin
          state_d = S_MEM;
          req_d   = 1'b1;
          we_d    = mem_we;
          sel_d   = mem_sel;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
        end else if (if_pend) begin
          state_d = S_IF;
          req_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = '1;
          addr_d  = if_addr;
          wdata_d = '0;
        end
      end
      S_MEM: begin
        if (bus_ack) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          mem_set = 1'b1;
        end
      end
      S_IF: begin
        if (bus_ack) begin
          state_d   = S_IDLE;
          req_d     = 1'b0;
          discard_d = 1'b0;
          // A flush on the ack cycle or earlier in the transfer drops the word.
          if_set    = ~discard_q & ~flush;
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q   <= S_IDLE;
      discard_q <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      req_q     <= req_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  mem_bus_arbiter_buf #(.DATA_W(DATA_W)) u_mem_buf (
    .clk    (clk),
    .rst    (rst),
    .set_i  (mem_set),
    .clr_i  (mem_clr),
    .data_i (bus_rdata),
    .done_o (mem_done),
    .data_o (mem_rdata)
  );

  mem_bus_arbiter_buf #(.DATA_W(DATA_W)) u_if_buf (
    .clk    (clk),
    .rst    (rst),
    .set_i  (if_set),
    .clr_i  (if_clr),
    .data_i (bus_rdata),
    .done_o (if_done),
    .data_o (if_inst)
  );

  assign stallreq_mem = mem_ce & ~mem_done;
  assign stallreq_if  = if_ce & ~if_done;

  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_sel   = sel_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        if_ce;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        stallreq_if;
  logic        mem_ce;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stallreq_mem;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int n_cmp = 0;
  int n_bad = 0;

  // Slave model: fixed number of wait states, read data derived from address.
  int          waits = 0;
  int          cnt = 0;
  logic [31:0] wr_addr = '0;
  logic [3:0]  wr_sel = '0;
  logic [31:0] wr_data = '0;

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    case (a)
      32'h0000_0000: slave_data = 32'h2402_0005;
      32'h0000_0100: slave_data = 32'hDEAD_BEEF;
      default:       slave_data = a + 32'h1000_0000;
    endcase
  endfunction

  assign bus_ack   = bus_req && (cnt == waits);
  assign bus_rdata = slave_data(bus_addr);

  always @(posedge clk) begin
    if (!bus_req || bus_ack) cnt <= 0;
    else cnt <= cnt + 1;
    if (bus_ack && bus_we) begin
      wr_addr <= bus_addr;
      wr_sel  <= bus_sel;
      wr_data <= bus_wdata;
    end
  end

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .if_ce        (if_ce),
    .if_addr      (if_addr),
    .if_inst      (if_inst),
    .stallreq_if  (stallreq_if),
    .mem_ce       (mem_ce),
    .mem_we       (mem_we),
    .mem_sel      (mem_sel),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .stallreq_mem (stallreq_mem),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_sel      (bus_sel),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack)
  );

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL rst_bus_req got=%0h exp=0", bus_req); end
    n_cmp++; if ({bus_we, bus_sel, bus_addr, bus_wdata} !== 69'd0) begin n_bad++; $display("FAIL rst_bus_fields got=%0h exp=0", {bus_we, bus_sel, bus_addr, bus_wdata}); end
    n_cmp++; if (if_inst !== 32'h0) begin n_bad++; $display("FAIL rst_if_inst got=%0h exp=0", if_inst); end
    n_cmp++; if (mem_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_mem_rdata got=%0h exp=0", mem_rdata); end
    n_cmp++; if ({stallreq_if, stallreq_mem} !== 2'b00) begin n_bad++; $display("FAIL rst_stallreq got=%0b exp=00", {stallreq_if, stallreq_mem}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch;
    waits = 0;
    if_ce = 1'b1; if_addr = 32'h0;
    #1;
    n_cmp++; if ({stallreq_if, bus_req} !== 2'b10) begin n_bad++; $display("FAIL fetch_c0 got=%0b exp=10", {stallreq_if, bus_req}); end
    @(negedge clk);
    n_cmp++; if ({stallreq_if, bus_req, bus_we} !== 3'b110) begin n_bad++; $display("FAIL fetch_c1 got=%0b exp=110", {stallreq_if, bus_req, bus_we}); end
    n_cmp++; if ({bus_sel, bus_addr} !== {4'hF, 32'h0}) begin n_bad++; $display("FAIL fetch_c1_bus got=%0h exp=%0h", {bus_sel, bus_addr}, {4'hF, 32'h0}); end
    @(negedge clk);
    n_cmp++; if ({stallreq_if, bus_req} !== 2'b00) begin n_bad++; $display("FAIL fetch_c2_ctl got=%0b exp=00", {stallreq_if, bus_req}); end
    n_cmp++; if (if_inst !== 32'h2402_0005) begin n_bad++; $display("FAIL fetch_inst got=%0h exp=24020005", if_inst); end
    if_ce = 1'b0;
    @(negedge clk);
    n_cmp++; if (if_inst !== 32'h0) begin n_bad++; $display("FAIL fetch_consumed got=%0h exp=0", if_inst); end
  endtask

  task automatic test_priority;
    waits = 0;
    if_ce = 1'b1; if_addr = 32'h40;
    mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h100; mem_wdata = 32'h0;
    @(negedge clk);
    n_cmp++; if ({bus_req, bus_we, bus_addr} !== {2'b10, 32'h100}) begin n_bad++; $display("FAIL prio_first got=%0h exp=%0h", {bus_req, bus_we, bus_addr}, {2'b10, 32'h100}); end
    n_cmp++; if ({stallreq_mem, stallreq_if} !== 2'b11) begin n_bad++; $display("FAIL prio_stall1 got=%0b exp=11", {stallreq_mem, stallreq_if}); end
    @(negedge clk);
    n_cmp++; if (mem_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL prio_rdata got=%0h exp=deadbeef", mem_rdata); end
    n_cmp++; if ({bus_req, stallreq_mem, stallreq_if} !== 3'b001) begin n_bad++; $display("FAIL prio_idle got=%0b exp=001", {bus_req, stallreq_mem, stallreq_if}); end
    mem_ce = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus_req, bus_addr, stallreq_if} !== {1'b1, 32'h40, 1'b1}) begin n_bad++; $display("FAIL prio_fetch got=%0h exp=%0h", {bus_req, bus_addr, stallreq_if}, {1'b1, 32'h40, 1'b1}); end
    n_cmp++; if (mem_rdata !== 32'h0) begin n_bad++; $display("FAIL prio_rdata_clr got=%0h exp=0", mem_rdata); end
    @(negedge clk);
    n_cmp++; if (if_inst !== 32'h1000_0040) begin n_bad++; $display("FAIL prio_inst got=%0h exp=10000040", if_inst); end
    if_ce = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wait_store;
    waits = 3;
    mem_ce = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h200; mem_wdata = 32'h0000_ABCD;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus_req, bus_we, bus_sel, bus_addr, bus_wdata, stallreq_mem} !== {2'b11, 4'b0011, 32'h200, 32'h0000_ABCD, 1'b1}) begin
        n_bad++;
        $display("FAIL store_hold_%0d got req=%0b sel=%0h addr=%0h wdata=%0h stall=%0b exp req=1 sel=3 addr=200 wdata=abcd stall=1",
                 k, bus_req, bus_sel, bus_addr, bus_wdata, stallreq_mem);
      end
      // Changing inputs mid-transfer must not reach the bus.
      mem_wdata = 32'h1111_0000 + k; mem_addr = 32'h300 + k;
    end
    @(negedge clk);
    n_cmp++; if ({bus_req, stallreq_mem} !== 2'b00) begin n_bad++; $display("FAIL store_done got=%0b exp=00", {bus_req, stallreq_mem}); end
    n_cmp++; if ({wr_sel, wr_addr, wr_data} !== {4'b0011, 32'h200, 32'h0000_ABCD}) begin n_bad++; $display("FAIL store_slave got=%0h exp=%0h", {wr_sel, wr_addr, wr_data}, {4'b0011, 32'h200, 32'h0000_ABCD}); end
    mem_ce = 1'b0; mem_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush;
    waits = 2;
    if_ce = 1'b1; if_addr = 32'h80;
    @(negedge clk);
    n_cmp++; if ({bus_req, bus_addr} !== {1'b1, 32'h80}) begin n_bad++; $display("FAIL flush_req got=%0h exp=%0h", {bus_req, bus_addr}, {1'b1, 32'h80}); end
    flush = 1'b1; if_addr = 32'h84;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if ({if_inst, bus_req, stallreq_if} !== {32'h0, 2'b01}) begin n_bad++; $display("FAIL flush_discard got inst=%0h req=%0b stall=%0b exp inst=0 req=0 stall=1", if_inst, bus_req, stallreq_if); end
    @(negedge clk);
    n_cmp++; if ({bus_req, bus_addr} !== {1'b1, 32'h84}) begin n_bad++; $display("FAIL flush_refetch got=%0h exp=%0h", {bus_req, bus_addr}, {1'b1, 32'h84}); end
    repeat (3) @(negedge clk);
    n_cmp++; if ({if_inst, stallreq_if} !== {32'h1000_0084, 1'b0}) begin n_bad++; $display("FAIL flush_newinst got=%0h exp=%0h", {if_inst, stallreq_if}, {32'h1000_0084, 1'b0}); end
    if_ce = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stall_hold;
    waits = 0;
    stall = 6'b000111;
    if_ce = 1'b1; if_addr = 32'h10;
    repeat (2) @(negedge clk);
    n_cmp++; if (if_inst !== 32'h1000_0010) begin n_bad++; $display("FAIL hold_inst got=%0h exp=10000010", if_inst); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({if_inst, bus_req} !== {32'h1000_0010, 1'b0}) begin
        n_bad++;
        $display("FAIL hold_cycle_%0d got inst=%0h req=%0b exp inst=10000010 req=0", k, if_inst, bus_req);
      end
    end
    stall = 6'b000000;
    @(negedge clk);
    n_cmp++; if ({if_inst, stallreq_if, bus_req} !== {32'h0, 2'b10}) begin n_bad++; $display("FAIL hold_release got inst=%0h stall=%0b req=%0b exp inst=0 stall=1 req=0", if_inst, stallreq_if, bus_req); end
    if_ce = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    waits = 5;
    mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h300;
    @(negedge clk);
    n_cmp++; if ({bus_req, bus_addr} !== {1'b1, 32'h300}) begin n_bad++; $display("FAIL rstmid_req got=%0h exp=%0h", {bus_req, bus_addr}, {1'b1, 32'h300}); end
    rst = 1'b1; mem_ce = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus_req, bus_we, bus_sel, bus_addr, bus_wdata} !== 70'd0) begin n_bad++; $display("FAIL rstmid_bus got=%0h exp=0", {bus_req, bus_we, bus_sel, bus_addr, bus_wdata}); end
    n_cmp++; if ({mem_rdata, if_inst, stallreq_mem, stallreq_if} !== 66'd0) begin n_bad++; $display("FAIL rstmid_outs got=%0h exp=0", {mem_rdata, if_inst, stallreq_mem, stallreq_if}); end
    rst = 1'b0; waits = 0; mem_ce = 1'b1;
    @(negedge clk);
    n_cmp++; if ({bus_req, bus_addr} !== {1'b1, 32'h300}) begin n_bad++; $display("FAIL rstmid_regrant got=%0h exp=%0h", {bus_req, bus_addr}, {1'b1, 32'h300}); end
    @(negedge clk);
    n_cmp++; if ({mem_rdata, stallreq_mem} !== {32'h1000_0300, 1'b0}) begin n_bad++; $display("FAIL rstmid_rdata got=%0h exp=%0h", {mem_rdata, stallreq_mem}, {32'h1000_0300, 1'b0}); end
    mem_ce = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0;
    if_ce = 1'b0; if_addr = '0;
    mem_ce = 1'b0; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
    test_reset;
    test_fetch;
    test_priority;
    test_wait_store;
    test_flush;
    test_stall_hold;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
